pipeline_hazard_ctrl: RTL
=========================

# pipeline_hazard_ctrl

Central stall/flush controller for the 5-stage MIPS pipeline. It drives the `enable`/`flush` pins of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC write enable. Inputs it resolves:
- load-use hazards
- taken branches resolved in EX
- multi-cycle data-memory waits
- mult/div unit occupancy

It sits beside the decode stage and is the only source of pipeline enable/flush signals in the core.

## Interface
- REG_ADDR_W, 5, register-file address width
- MULDIV_CYCLES, 32, EX-stage busy cycles of a mult/div after issue (≥1)
- STALL_CNT_W, 16, width of the stall performance counter

Ports:
- clk  in  1  core clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- id_rs, id_rt  in  REG_ADDR_W  source registers of instruction in ID
- id_uses_rs, id_uses_rt  in  1  ID instruction actually reads rs / rt
- id_muldiv  in  1  ID instruction is mult/multu/div/divu
- id_reads_hilo  in  1  ID instruction is mfhi/mflo
- ex_mem_read  in  1  instruction in EX is a load
- ex_rt  in  REG_ADDR_W  destination register of the load in EX
- ex_branch_taken  in  1  branch/jump in EX resolved taken
- dmem_req  in  1  MEM stage is accessing data memory this cycle
- dmem_ready  in  1  data memory completes the access this cycle
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1  register enables
- if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1  synchronous clears
- muldiv_busy  out  1  mult/div result not yet available
- mem_wait  out  1  FSM in MEM_WAIT
- stall_cnt  out  STALL_CNT_W  saturating count of cycles with pc_en=0 in RUN/MEM_WAIT

## Operation
FSM states:
- INIT: entered on reset. All enables 0, all flushes 1. Goes to RUN on the first clock edge after reset deasserts.
- RUN: normal operation. Goes to MEM_WAIT when freeze=1.
- MEM_WAIT: returns to RUN on the edge where dmem_ready=1.

Derived signals:
- freeze = dmem_req & ~dmem_ready.
- load_use = ex_mem_read & (ex_rt≠0) & ((id_uses_rs & id_rs==ex_rt) | (id_uses_rt & id_rt==ex_rt)).
- hilo_stall = muldiv_busy & (id_reads_hilo | id_muldiv).

Output priority in RUN/MEM_WAIT, highest first:
1. freeze: all enables 0, all flushes 0. The whole pipe holds, including the EX branch decision.
2. ex_branch_taken: all enables 1, if_id_flush=1, id_ex_flush=1. This overrides load_use/hilo_stall because the stalled instruction is squashed anyway.
3. load_use | hilo_stall: pc_en=0, if_id_en=0, id_ex_flush=1 (bubble), ex_mem_en=mem_wb_en=1.
4. Otherwise: all enables 1, all flushes 0.

ex_mem_flush and mem_wb_flush are asserted only in INIT.

Mult/div counter (CNT, width clog2(MULDIV_CYCLES+1)):
- Loads MULDIV_CYCLES when id_muldiv is accepted, i.e. case 4 applies with id_muldiv=1.
- Otherwise decrements while nonzero, including during freeze.
- muldiv_busy = (CNT≠0), registered.

stall_cnt:
- Increments when state≠INIT and pc_en=0.
- Holds at all-ones.
- Cleared only by reset.

## Timing
- All enable/flush outputs are combinational from current state and inputs. They take effect at the next rising edge of clk in the pipeline registers.
- Reset values: state=INIT, CNT=0, stall_cnt=0, muldiv_busy=0, mem_wait=0, pc_en=0, all *_en=0, all *_flush=1.
- Load-use costs exactly 1 bubble cycle. After the edge, the load is in MEM and ex_mem_read refers to the bubble, so the stall drops.
- The ready cycle of a memory access is not a freeze cycle. A request ready in the same cycle causes no stall and no MEM_WAIT entry.
- Mult/div issued at edge T: muldiv_busy=1 from T until edge T+MULDIV_CYCLES. A dependent mfhi in ID stalls until then and advances at that edge.
- Reset mid-operation (any state, any CNT): everything returns to INIT immediately and asynchronously. No pending stall survives reset.
- Branch and freeze in the same cycle: freeze wins. The branch flush is applied on the first non-freeze cycle, because EX is held.

## Test plan
- Reset release: reset=1 for 3 cycles, then 0 → INIT outputs (pc_en=0, all flushes=1) during reset, RUN one edge later, all enables=1, stall_cnt=0.
- Load-use: ex_mem_read=1, ex_rt=8, id_rs=8, id_uses_rs=1 → one cycle with pc_en=0, if_id_en=0, id_ex_flush=1; stall_cnt=1. Repeat with ex_rt=0 → no stall.
- Branch over hazard: load-use condition plus ex_branch_taken=1 → pc_en=1, if_id_flush=id_ex_flush=1, stall_cnt unchanged.
- Memory wait: dmem_req=1, dmem_ready=0 for 3 cycles, then 1 → all enables 0 for 3 cycles, mem_wait=1 on cycles 2–4 after entry, RUN after the ready edge, stall_cnt=3.
- Mult/div: MULDIV_CYCLES=4; issue mult, then mfhi in ID → mfhi held 4 cycles, muldiv_busy falls exactly 4 edges after issue. Back-to-back mult → second mult stalls likewise.
- Reset mid-mult/div: assert reset 2 cycles after issue → muldiv_busy=0 and CNT=0 immediately. After release, mfhi proceeds without stall.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Central stall/flush controller for the 5-stage MIPS pipeline. It is the
//   only source of the pipeline-register enable/flush pins and the PC write
//   enable. It resolves load-use hazards, taken branches from EX,
//   multi-cycle data-memory waits and mult/div (HI/LO) occupancy.
//
// Ports
//   clk, reset           core clock; asynchronous active-high reset
//   id_rs, id_rt         source registers of the instruction in ID
//   id_uses_rs/rt        ID instruction really reads rs / rt
//   id_muldiv            ID instruction is mult/multu/div/divu
//   id_reads_hilo        ID instruction is mfhi/mflo
//   ex_mem_read, ex_rt   load in EX and its destination register
//   ex_branch_taken      branch/jump in EX resolved taken
//   dmem_req, dmem_ready MEM-stage data-memory access and its completion
//   *_en, *_flush        pipeline register enables / synchronous clears
//   muldiv_busy          mult/div result not yet available
//   mem_wait             FSM is in MEM_WAIT (doubles as FSM state visibility)
//   stall_cnt            saturating count of cycles with pc_en=0 after INIT
//
// Handshake: dmem_req/dmem_ready is a valid/ready pair. The access completes
// in the cycle where both are 1; a cycle with dmem_req=1 and dmem_ready=0 is
// a freeze cycle, and the ready cycle itself never freezes the pipe.
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W    = 5,
    parameter int MULDIV_CYCLES = 32,
    parameter int STALL_CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [REG_ADDR_W-1:0]  id_rs,
    input  logic [REG_ADDR_W-1:0]  id_rt,
    input  logic                   id_uses_rs,
    input  logic                   id_uses_rt,
    input  logic                   id_muldiv,
    input  logic                   id_reads_hilo,
    input  logic                   ex_mem_read,
    input  logic [REG_ADDR_W-1:0]  ex_rt,
    input  logic                   ex_branch_taken,
    input  logic                   dmem_req,
    input  logic                   dmem_ready,
    output logic                   pc_en,
    output logic                   if_id_en,
    output logic                   id_ex_en,
    output logic                   ex_mem_en,
    output logic                   mem_wb_en,
    output logic                   if_id_flush,
    output logic                   id_ex_flush,
    output logic                   ex_mem_flush,
    output logic                   mem_wb_flush,
    output logic                   muldiv_busy,
    output logic                   mem_wait,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam int CNT_W = $clog2(MULDIV_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_INIT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic             active;
    logic             freeze;
    logic             load_use;
    logic             hilo_stall;
    logic             accept_muldiv;

    assign active     = (state == ST_RUN) || (state == ST_MEM_WAIT);
    assign freeze     = dmem_req & ~dmem_ready;
    // $zero is never a real dependency, so a load to r0 never stalls.
    assign load_use   = ex_mem_read && (ex_rt != '0) &&
                        ((id_uses_rs && (id_rs == ex_rt)) ||
                         (id_uses_rt && (id_rt == ex_rt)));
    assign hilo_stall = muldiv_busy & (id_reads_hilo | id_muldiv);

    assign muldiv_busy = (cnt != '0);
    assign mem_wait    = (state == ST_MEM_WAIT);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_INIT;
        end else begin
            state <= state_next;
        end
    end

    // Next state
    always_comb begin
        state_next = state;
        case (state)
            ST_INIT:     state_next = ST_RUN;
            ST_RUN:      if (freeze) state_next = ST_MEM_WAIT;
            ST_MEM_WAIT: if (dmem_ready) state_next = ST_RUN;
            default:     state_next = ST_INIT;
        endcase
    end

    // Enable/flush outputs, in priority order: freeze, branch, hazard, run.
    always_comb begin
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        id_ex_en      = 1'b0;
        ex_mem_en     = 1'b0;
        mem_wb_en     = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_flush  = 1'b0;
        mem_wb_flush  = 1'b0;
        accept_muldiv = 1'b0;
        if (!active) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (freeze) begin
            // Whole pipe holds, the branch decision in EX included.
        end else if (ex_branch_taken) begin
            // Squashes the wrong-path instructions, which also removes any
            // instruction that would otherwise have stalled in ID.
            pc_en       = 1'b1;
            if_id_en    = 1'b1;
            id_ex_en    = 1'b1;
            ex_mem_en   = 1'b1;
            mem_wb_en   = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use || hilo_stall) begin
            // Hold IF/ID and PC, insert a bubble into ID/EX.
            id_ex_en    = 1'b1;
            id_ex_flush = 1'b1;
            ex_mem_en   = 1'b1;
            mem_wb_en   = 1'b1;
        end else begin
            pc_en         = 1'b1;
            if_id_en      = 1'b1;
            id_ex_en      = 1'b1;
            ex_mem_en     = 1'b1;
            mem_wb_en     = 1'b1;
            accept_muldiv = id_muldiv;
        end
    end

    // Mult/div occupancy: keeps counting down through freezes because the
    // unit runs independently of the pipeline registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (accept_muldiv) begin
            cnt <= CNT_W'(MULDIV_CYCLES);
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Stall performance counter, saturating at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (active && !pc_en && !(&stall_cnt)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule
